// File: rtl/approx_add_pkg.sv
// Shared definitions for the approximate adder pipeline: mode encodings,
// the widest result the helpers handle, and an absolute-difference helper.
package approx_add_pkg;

  // Widest result: W is at most 32, plus the carry-out bit
  localparam int MAX_OW = 33;

  // Encoding 3 is reserved and decodes as exact
  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // |x - y| on unsigned operands; callers zero-extend to MAX_OW
  function automatic logic [MAX_OW-1:0] abs_diff(input logic [MAX_OW-1:0] x,
                                                 input logic [MAX_OW-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_add_seg.sv
// N-bit ripple-carry adder slice with carry-in and carry-out.
module approx_add_seg #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Explicit bit-serial carry chain, LSB first
  always_comb begin : ripple
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Two-stage approximate adder with valid/ready flow control and error
// statistics. Stage 1 resolves the low K bits and the carry into the upper
// part according to MODE; stage 2 adds the upper W-K bits. The exact sum
// travels with each item so the output side can measure the error.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int W  = 8,
  parameter int K  = 4,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [1:0]    MODE,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [W:0]    O,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [CW-1:0] ERR_CNT,
  output logic [W:0]    MAX_ERR,
  input  logic          CLR_STAT
);

  localparam int HW     = W - K;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [K-1:0]  lo;
    logic          cin;
    logic [HW-1:0] a_hi;
    logic [HW-1:0] b_hi;
    logic [W:0]    exact;
  } s1_t;

  typedef struct packed {
    logic [W:0] o;
    logic [W:0] exact;
  } s2_t;

  logic [STAGES:1]   vld_pipe;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic              adv1, adv2;
  logic [K-1:0]      lo_sum;
  logic              lo_cout;
  logic [HW-1:0]     hi_sum;
  logic              hi_cout;
  logic              out_hs;
  logic [MAX_OW-1:0] err;

  // A stage moves when it is empty or its successor moves; ready is
  // combinational from OUT_READY so a full-rate stream never bubbles.
  assign adv2     = !vld_pipe[2] || OUT_READY;
  assign adv1     = !vld_pipe[1] || adv2;
  assign IN_READY = adv1;

  approx_add_seg #(.N(K)) u_seg_lo (
    .a    (A[K-1:0]),
    .b    (B[K-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // Stage 1: pick the low bits and upper carry-in for the selected mode
  always_comb begin
    s1_d.lo    = lo_sum;
    s1_d.cin   = lo_cout;
    s1_d.a_hi  = A[W-1:K];
    s1_d.b_hi  = B[W-1:K];
    s1_d.exact = {1'b0, A} + {1'b0, B};
    case (mode_e'(MODE))
      MODE_LOA: begin
        s1_d.lo  = A[K-1:0] | B[K-1:0];
        s1_d.cin = A[K-1] & B[K-1];
      end
      MODE_TRUNC: begin
        s1_d.lo  = '0;
        s1_d.cin = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage 1 register; payload only loads on a real acceptance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
    end else if (adv1) begin
      vld_pipe[1] <= IN_VALID;
      if (IN_VALID) s1_q <= s1_d;
    end
  end

  approx_add_seg #(.N(HW)) u_seg_hi (
    .a    (s1_q.a_hi),
    .b    (s1_q.b_hi),
    .cin  (s1_q.cin),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Stage 2: assemble the full result with carry-out on top
  always_comb begin
    s2_d.o     = {hi_cout, hi_sum, s1_q.lo};
    s2_d.exact = s1_q.exact;
  end

  // Stage 2 register doubles as the output holding register under stall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe[2] <= 1'b0;
      s2_q        <= '0;
    end else if (adv2) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) s2_q <= s2_d;
    end
  end

  assign O         = s2_q.o;
  assign OUT_VALID = vld_pipe[2];
  assign out_hs    = vld_pipe[2] && OUT_READY;
  assign err       = abs_diff(MAX_OW'(s2_q.exact), MAX_OW'(s2_q.o));

  // Error statistics on delivered results; clear takes priority
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_CNT <= '0;
      MAX_ERR <= '0;
    end else if (CLR_STAT) begin
      ERR_CNT <= '0;
      MAX_ERR <= '0;
    end else if (out_hs && (err != '0)) begin
      if (ERR_CNT != {CW{1'b1}}) ERR_CNT <= ERR_CNT + CW'(1);
      if (err > MAX_OW'(MAX_ERR)) MAX_ERR <= err[W:0];
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: directed vectors with literal expectations plus
// a queue-based reference model checked every cycle on the falling edge.
module tb_approx_add_pipe;

  localparam int W  = 8;
  localparam int K  = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [1:0]    MODE = '0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [W:0]    O;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic [CW-1:0] ERR_CNT;
  logic [W:0]    MAX_ERR;
  logic          CLR_STAT = 1'b0;

  approx_add_pipe #(.W(W), .K(K), .CW(CW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .A         (A),
    .B         (B),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .O         (O),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ERR_CNT   (ERR_CNT),
    .MAX_ERR   (MAX_ERR),
    .CLR_STAT  (CLR_STAT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W:0] o;
    int         ex;
    int         cyc;
  } item_t;

  item_t q[$];
  int    cyc   = 0;
  int    m_cnt = 0;
  int    m_max = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result from the mode rules, in plain integer arithmetic
  function automatic logic [W:0] model_o(input int a, input int b, input int m);
    int p  = 1 << K;
    int al = a % p;
    int bl = b % p;
    int ah = a / p;
    int bh = b / p;
    int r;
    case (m)
      1:       r = (ah + bh + ((al >= p / 2 && bl >= p / 2) ? 1 : 0)) * p + (al | bl);
      2:       r = (ah + bh) * p;
      default: r = a + b;
    endcase
    return (W + 1)'(r);
  endfunction

  // Every-cycle comparison against the model. An item presented in cycle c
  // must be on the output from cycle c+2 until it is taken.
  always @(negedge CLK) begin : cmp
    bit ev;
    int e;
    cyc++;
    if (!RST_N) begin
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_o", O, 0);
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_err_cnt", ERR_CNT, 0);
      chk("rst_max_err", MAX_ERR, 0);
      q.delete();
      m_cnt = 0;
      m_max = 0;
    end else begin
      ev = (q.size() > 0) && (q[0].cyc <= cyc - 2);
      chk("out_valid", OUT_VALID, ev);
      if (ev) chk("o", O, q[0].o);
      chk("in_ready", IN_READY, !(q.size() == 2 && !OUT_READY));
      chk("err_cnt", ERR_CNT, m_cnt);
      chk("max_err", MAX_ERR, m_max);
      if (OUT_VALID && OUT_READY && q.size() > 0) begin
        e = q[0].ex - int'(q[0].o);
        if (e < 0) e = -e;
        if (e != 0) begin
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          if (e > m_max) m_max = e;
        end
        void'(q.pop_front());
      end
      if (CLR_STAT) begin
        m_cnt = 0;
        m_max = 0;
      end
      if (IN_VALID && IN_READY)
        q.push_back('{o: model_o(int'(A), int'(B), int'(MODE)), ex: int'(A) + int'(B), cyc: cyc});
    end
  end

  // Present one operand and return just after the edge that accepts it
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    A = a; B = b; MODE = m; IN_VALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (IN_READY) break;
    end
    if (!IN_READY) chk("accept_timeout", IN_READY, 1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  // Single operand through an empty pipe with literal result and statistics
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                          input logic [W:0] exp_o, input int exp_cnt, input int exp_max);
    send(a, b, m);
    chk("lat1_valid", OUT_VALID, 0);
    @(posedge CLK); #1;
    chk("lat2_valid", OUT_VALID, 1);
    chk("o_lit", O, exp_o);
    @(posedge CLK); #1;
    chk("cnt_lit", ERR_CNT, exp_cnt);
    chk("max_lit", MAX_ERR, exp_max);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (q.size() == 0) break;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge CLK); #1;
  endtask

  logic [W-1:0] sa [10] = '{8'h3C, 8'h0F, 8'h88, 8'hF7, 8'hFF, 8'h5A, 8'h09, 8'h80, 8'h33, 8'h7E};
  logic [W-1:0] sb [10] = '{8'h47, 8'h01, 8'h88, 8'h19, 8'h01, 8'hA5, 8'h0E, 8'h80, 8'h0C, 8'h7E};
  logic [1:0]   sm [10] = '{2'd0,  2'd1,  2'd1,  2'd2,  2'd3,  2'd1,  2'd2,  2'd0,  2'd1,  2'd2};

  initial begin
    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_in_ready", IN_READY, 1);
    chk("reset_out_valid", OUT_VALID, 0);
    chk("reset_o", O, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // single-operand vectors, statistics accumulate across them
    directed(8'hFF, 8'hFF, 2'd0, 9'h1FE, 0, 0);
    directed(8'h0F, 8'h01, 2'd1, 9'h00F, 1, 1);
    directed(8'h0F, 8'h01, 2'd2, 9'h000, 2, 16);
    directed(8'h08, 8'h08, 2'd1, 9'h018, 3, 16);
    directed(8'h7F, 8'h01, 2'd3, 9'h080, 3, 16);

    // clear coinciding with an erroneous handshake
    send(8'h0F, 8'h01, 2'd2);
    @(posedge CLK); #1;
    chk("clr_pre_valid", OUT_VALID, 1);
    CLR_STAT = 1'b1;
    @(posedge CLK); #1;
    CLR_STAT = 1'b0;
    chk("clr_cnt", ERR_CNT, 0);
    chk("clr_max", MAX_ERR, 0);

    // mixed-mode stream with OUT_READY pattern 1,0,0
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          A = sa[i]; B = sb[i]; MODE = sm[i]; IN_VALID = 1'b1;
          for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (IN_READY) break;
          end
          if (!IN_READY) chk("stream_accept_timeout", IN_READY, 1);
          @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          OUT_READY = (c % 3 == 0);
          @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
      end
    join
    drain();

    // reset with two items in flight
    OUT_READY = 1'b0;
    send(8'h11, 8'h22, 2'd0);
    send(8'h0F, 8'h01, 2'd2);
    chk("inflight_valid", OUT_VALID, 1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_valid", OUT_VALID, 0);
    chk("async_rst_o", O, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      chk("no_stale", OUT_VALID, 0);
    end
    directed(8'h12, 8'h34, 2'd0, 9'h046, 0, 0);

    // counter saturation: 20 results each off by 16
    for (int i = 0; i < 20; i++) send(8'h0F, 8'h01, 2'd2);
    drain();
    chk("sat_cnt", ERR_CNT, 15);
    chk("sat_max", MAX_ERR, 16);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
